osd_ctm_mmsp430_mc: RTL and testbench
=====================================

Name: osd_ctm_mmsp430_mc

Overview:
Multi-channel core trace module for MMSP430 clusters: captures control-flow (or all) retired-instruction events from CHANNELS cores. Each event is timestamped and buffered in a per-channel FIFO. Events are serialised as OSD EVENT packets onto one DII output.
Successor to the single-core CTM adapter: adds channel count, buffering depth, filter mode, loss accounting and a native packetiser.
Sits between the core trace ports and the debug ring router.

Parameters:
CHANNELS, 2, number of traced cores (1..16)
FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2)
ADDR_WIDTH, 32, PC width (fixed 32; packet format depends on it)
FILTER_CF, 1, 1: capture only valid&&(jal||jr); 0: capture every valid

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (asserted at 0)
id  in  16  own DI address, sent as packet source
event_dest  in  16  destination DI address of event packets
enable  in  1  capture enable
trace_valid  in  CHANNELS  per-channel retire strobe
trace_pc  in  CHANNELS*32  per-channel PC; channel c at [32c+31:32c]
trace_npc  in  CHANNELS*32  per-channel jump/branch target
trace_jal  in  CHANNELS  per-channel jal flag
trace_jr  in  CHANNELS  per-channel jr flag
debug_out  out  dii_flit  {valid,last,data[15:0]} packet output
debug_out_ready  in  1  downstream ready
overflow  out  CHANNELS  sticky per-channel "an event was dropped since reset"

Behaviour:
- Reset (rst=0, async): debug_out.valid=0, last=0, data=0; overflow=0; all FIFOs empty; timestamp=0; lost counters=0; rr pointer=0; FSM IDLE.
- Timestamp: free-running 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0.
- Capture: event on channel c = enable && trace_valid[c] && (FILTER_CF ? jal[c]||jr[c] : 1). Pushes {ts, pc, npc, jal, jr} at that edge.
- Full: fullness is evaluated on the pre-pop state. An event arriving while full is dropped, even if the same cycle pops. A drop sets overflow[c] and increments lost[c] (10-bit, saturates at 1023).
- enable low: no pushes. Buffered events and any in-flight packet still drain.
- Arbiter: in IDLE, grants the first non-empty channel at or after rr pointer (wrapping). rr pointer becomes granted+1 mod CHANNELS.
- Grant capture: lost[granted] is snapshot into the packet and cleared. A drop in the grant cycle makes lost=1, not 0.
- FSM: IDLE -> SEND on grant. SEND has a flit index 0..9. Index advances only on valid&&ready. On index 9 accepted: pop FIFO, go IDLE. No idle cycle is required before the next grant, but the registered output may insert one.
- Packet, 10 flits, last=1 only on flit 9:
  0 event_dest
  1 id
  2 16'h8000 (TYPE=EVENT 2'b10, subtype 0)
  3 ts[15:0]
  4 ts[31:16]
  5 {ch[3:0], jal, jr, lost[9:0]}
  6 pc[15:0]
  7 pc[31:16]
  8 npc[15:0]
  9 npc[31:16]
- Handshake: once valid=1, data and last stay stable until ready. valid never drops mid-packet.
- Latency: event captured at edge N -> flit 0 valid in cycle N+2 when idle and ready=1. Back-to-back packets from one channel give >=10 flits per event.
- Simultaneous events on all channels in one cycle: all pushed. They are emitted in rr order.
- Reset mid-packet: output is deasserted immediately. The partial packet is abandoned, with no completion.

Test Plan:
- Single jal event, CHANNELS=2: ch1 valid,jal,pc=0x00001234,npc=0x00005678 at ts=7 -> flits 0..9 = {dest, id, 8000, 0007, 0000, 1800, 1234, 0000, 5678, 0000}, last on flit 9, first flit 2 cycles after capture.
- Filter: FILTER_CF=1, valid with jal=jr=0 -> no packet. FILTER_CF=0, same stimulus -> packet with flit5[11:10]=00.
- Overflow: ready=0, 6 events on ch0 with FIFO_DEPTH=4 -> overflow[0]=1. After ready=1: 4 packets. First packet flit5[9:0]=2; the others 0.
- Round robin: ch0 and ch1 events in the same cycle, rr=0 -> ch0 packet then ch1. Next simultaneous pair -> ch0 first again, since rr=0 after ch1 grant.
- Backpressure: toggle ready randomly -> data/last stable while valid&&!ready. No flit lost or duplicated; 10 flits per packet.
- Reset mid-packet at flit 4 -> valid=0 asynchronously, FIFOs empty, timestamp restarts at 0. A new event produces a full 10-flit packet.

Source files
------------

// File: rtl/osd_ctm_mmsp430_mc.sv
// Multi-channel MMSP430 trace capture: per-channel timestamped event FIFOs, round-robin packetiser to 10-flit OSD EVENT packets.
// Latency: event captured at edge N -> grant at edge N+1 -> flit 0 valid before edge N+2 (accepted there if ready).
// Backpressure: flits hold while !debug_out_ready; full FIFOs drop new events, set overflow and count them in lost.
module osd_ctm_mmsp430_mc #(
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter bit FILTER_CF  = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [15:0]                    id,
  input  logic [15:0]                    event_dest,
  input  logic                           enable,
  input  logic [CHANNELS-1:0]            trace_valid,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] trace_pc,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] trace_npc,
  input  logic [CHANNELS-1:0]            trace_jal,
  input  logic [CHANNELS-1:0]            trace_jr,
  output logic [17:0]                    debug_out,
  input  logic                           debug_out_ready,
  output logic [CHANNELS-1:0]            overflow
);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int EW     = 32 + 2*ADDR_WIDTH + 2;
  localparam int TS_LO  = 2*ADDR_WIDTH + 2;
  localparam int PC_LO  = ADDR_WIDTH + 2;
  localparam int NPC_LO = 2;
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [CW-1:0]       rr_q, gnt_q, sel;
  logic                grant;
  logic [9:0]          pkt_lost_q;
  logic [31:0]         ts_q;
  logic [EW-1:0]       mem_q  [CHANNELS][FIFO_DEPTH];
  logic [PW-1:0]       wptr_q [CHANNELS];
  logic [PW-1:0]       rptr_q [CHANNELS];
  logic [PW:0]         cnt_q  [CHANNELS];
  logic [9:0]          lost_q [CHANNELS];
  logic [9:0]          lost_d [CHANNELS];
  logic [CHANNELS-1:0] ev, push, drop, pop, nonempty, ovf_q;
  logic [EW-1:0]       head;
  logic [15:0]         flit;

  // Event qualification; full/drop uses the pre-pop count so a same-cycle pop never rescues an event.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      ev[c]       = enable && trace_valid[c] && (!FILTER_CF || trace_jal[c] || trace_jr[c]);
      nonempty[c] = (cnt_q[c] != '0);
      push[c]     = ev[c] && (cnt_q[c] != FULL);
      drop[c]     = ev[c] && (cnt_q[c] == FULL);
      pop[c]      = (state_q == SEND) && (idx_q == 4'd9) && debug_out_ready && (gnt_q == CW'(c));
    end
  end

  // Round-robin search: first non-empty channel at or after rr_q, only while idle.
  always_comb begin
    grant = 1'b0;
    sel   = rr_q;
    for (int i = CHANNELS-1; i >= 0; i--) begin
      if (nonempty[(int'(rr_q) + i) % CHANNELS]) begin
        grant = 1'b1;
        sel   = CW'((int'(rr_q) + i) % CHANNELS);
      end
    end
    if (state_q != IDLE) grant = 1'b0;
  end

  // Lost counters: snapshot-and-clear on grant (a drop in that cycle leaves 1), else saturating count of drops.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      lost_d[c] = lost_q[c];
      if (grant && (sel == CW'(c))) lost_d[c] = drop[c] ? 10'd1 : 10'd0;
      else if (drop[c] && (lost_q[c] != 10'h3FF)) lost_d[c] = lost_q[c] + 10'd1;
    end
  end

  // Free-running timestamp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + 32'd1;
  end

  // FIFO payload storage; emptiness lives in the reset counters, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= {ts_q, trace_pc[c*ADDR_WIDTH +: ADDR_WIDTH],
                                           trace_npc[c*ADDR_WIDTH +: ADDR_WIDTH], trace_jal[c], trace_jr[c]};
    end
  end

  // FIFO pointers, occupancy, lost counters and sticky overflow flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
        lost_q[c] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (push[c]) wptr_q[c] <= wptr_q[c] + PW'(1);
        if (pop[c])  rptr_q[c] <= rptr_q[c] + PW'(1);
        cnt_q[c]  <= cnt_q[c] + (PW+1)'(push[c]) - (PW+1)'(pop[c]);
        lost_q[c] <= lost_d[c];
        if (drop[c]) ovf_q[c] <= 1'b1;
      end
    end
  end

  // Grant bookkeeping: channel in flight, next rr start and the lost snapshot for flit 5.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q      <= '0;
      rr_q       <= '0;
      pkt_lost_q <= '0;
    end else if (grant) begin
      gnt_q      <= sel;
      rr_q       <= CW'((int'(sel) + 1) % CHANNELS);
      pkt_lost_q <= lost_q[sel];
    end
  end

  // Packetiser state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Packetiser next state: flit index advances only on an accepted flit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = SEND;
        idx_d   = '0;
      end
      SEND: if (debug_out_ready) begin
        if (idx_q == 4'd9) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The head entry is only popped after flit 9, so it is stable for the whole packet.
  assign head = mem_q[gnt_q][rptr_q[gnt_q]];

  // Flit selection by index.
  always_comb begin
    flit = '0;
    case (idx_q)
      4'd0:    flit = event_dest;
      4'd1:    flit = id;
      4'd2:    flit = 16'h8000;
      4'd3:    flit = head[TS_LO +: 16];
      4'd4:    flit = head[TS_LO+16 +: 16];
      4'd5:    flit = {4'(gnt_q), head[1], head[0], pkt_lost_q};
      4'd6:    flit = head[PC_LO +: 16];
      4'd7:    flit = head[PC_LO+16 +: 16];
      4'd8:    flit = head[NPC_LO +: 16];
      4'd9:    flit = head[NPC_LO+16 +: 16];
      default: flit = '0;
    endcase
  end

  assign debug_out = {(state_q == SEND), (state_q == SEND) && (idx_q == 4'd9),
                      (state_q == SEND) ? flit : 16'h0000};
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_osd_ctm_mmsp430_mc.sv
// Self-checking bench for osd_ctm_mmsp430_mc: directed scenarios plus randomized backpressure traffic.
// Reference: per-event packet builder, timestamp counter and in-order per-channel scoreboard.
// Inputs change 1 time unit after posedge; the output monitor samples on negedge.
module tb_osd_ctm_mmsp430_mc;
  localparam int CH = 2;
  localparam int DEPTH = 4;
  localparam logic [15:0] DEST = 16'hA5C3;
  localparam logic [15:0] ID   = 16'h0042;

  typedef logic [159:0] pkt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] id = ID;
  logic [15:0] event_dest = DEST;
  logic        enable = 1'b1;
  logic [1:0]  trace_valid = '0, trace_jal = '0, trace_jr = '0;
  logic [63:0] trace_pc = '0, trace_npc = '0;
  logic        ready = 1'b1;
  logic [17:0] debug_out0, debug_out1;
  logic [1:0]  overflow0, overflow1;

  osd_ctm_mmsp430_mc #(.CHANNELS(CH), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(32), .FILTER_CF(1'b1)) dut (
    .clk(clk), .rst(rst), .id(id), .event_dest(event_dest), .enable(enable),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_npc(trace_npc),
    .trace_jal(trace_jal), .trace_jr(trace_jr), .debug_out(debug_out0),
    .debug_out_ready(ready), .overflow(overflow0));

  osd_ctm_mmsp430_mc #(.CHANNELS(CH), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(32), .FILTER_CF(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .id(id), .event_dest(event_dest), .enable(enable),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_npc(trace_npc),
    .trace_jal(trace_jal), .trace_jr(trace_jr), .debug_out(debug_out1),
    .debug_out_ready(ready), .overflow(overflow1));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int stab_viol = 0, fmt_err = 0;
  logic [31:0] tsm;
  pkt_t pkt_q[$];
  int   pkt_tq[$];
  pkt_t exp_q[$];

  // Reference timestamp: cycles since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) tsm <= '0;
    else      tsm <= tsm + 32'd1;
  end

  // Output monitor: assembles accepted flits into packets and records hold/format violations.
  int   mon_idx = 0;
  logic hold_vld = 1'b0;
  logic [17:0] hold_flit = '0;
  pkt_t cur = '0;
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      mon_idx  = 0;
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && (debug_out0 !== hold_flit)) stab_viol++;
      hold_vld  = debug_out0[17] && !ready;
      hold_flit = debug_out0;
      if (debug_out0[17] && ready) begin
        cur[mon_idx*16 +: 16] = debug_out0[15:0];
        if (debug_out0[16] != (mon_idx == 9)) fmt_err++;
        if (debug_out0[16] || mon_idx == 9) begin
          pkt_q.push_back(cur);
          pkt_tq.push_back(int'(tsm));
          mon_idx = 0;
        end else begin
          mon_idx++;
        end
      end
    end
  end

  function automatic pkt_t mk_pkt(input int ch, input logic [31:0] ts, input logic [31:0] pc,
                                  input logic [31:0] npc, input logic j, input logic r,
                                  input logic [9:0] lost);
    pkt_t p;
    p[15:0]    = DEST;
    p[31:16]   = ID;
    p[47:32]   = 16'h8000;
    p[63:48]   = ts[15:0];
    p[79:64]   = ts[31:16];
    p[95:80]   = {4'(ch), j, r, lost};
    p[111:96]  = pc[15:0];
    p[127:112] = pc[31:16];
    p[143:128] = npc[15:0];
    p[159:144] = npc[31:16];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    trace_valid = '0; trace_jal = '0; trace_jr = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) tick();
  endtask

  // Present one cycle of trace inputs; the filtered model records every event that must appear.
  task automatic drive(input logic [1:0] v, input logic [1:0] j, input logic [1:0] r,
                       input logic [31:0] pc0, input logic [31:0] npc0,
                       input logic [31:0] pc1, input logic [31:0] npc1);
    trace_valid = v; trace_jal = j; trace_jr = r;
    trace_pc = {pc1, pc0}; trace_npc = {npc1, npc0};
    for (int c = 0; c < CH; c++)
      if (enable && v[c] && (j[c] || r[c]))
        exp_q.push_back(mk_pkt(c, tsm, (c == 0) ? pc0 : pc1, (c == 0) ? npc0 : npc1, j[c], r[c], 10'd0));
    tick();
  endtask

  task automatic wait_pkts(input int n, input int budget, input string name);
    int k;
    k = 0;
    clear_inputs();
    while (pkt_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (pkt_q.size() < n) begin
      failures++;
      $display("FAIL %s_timeout: got %0d packets, required %0d", name, pkt_q.size(), n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    enable = 1'b1;
    ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    pkt_q.delete(); pkt_tq.delete(); exp_q.delete();
    stab_viol = 0; fmt_err = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    checks++;
    if (debug_out0 !== 18'h0) begin failures++; $display("FAIL reset_out: got %h required 0", debug_out0); end
    checks++;
    if (overflow0 !== 2'b00) begin failures++; $display("FAIL reset_ovf: got %b required 00", overflow0); end
    rst = 1'b1;
    pkt_q.delete(); pkt_tq.delete(); exp_q.delete();
    idle(12);
    checks++;
    if (pkt_q.size() != 0 || debug_out0[17] !== 1'b0) begin
      failures++; $display("FAIL reset_idle: got %0d packets valid=%b required none", pkt_q.size(), debug_out0[17]);
    end
  endtask

  task automatic test_single_jal();
    int k;
    do_reset();
    k = 0;
    while (tsm != 32'd7 && k < 20) begin tick(); k++; end
    drive(2'b10, 2'b10, 2'b00, 32'h0, 32'h0, 32'h0000_1234, 32'h0000_5678);
    clear_inputs();
    checks++;
    if (debug_out0[17] !== 1'b0) begin failures++; $display("FAIL lat_early: valid=%b one edge after capture, required 0", debug_out0[17]); end
    tick();
    checks++;
    if (debug_out0 !== {2'b10, DEST}) begin failures++; $display("FAIL lat_flit0: got %h required %h", debug_out0, {2'b10, DEST}); end
    wait_pkts(1, 40, "single");
    if (pkt_q.size() >= 1) begin
      checks++;
      if (pkt_q[0] !== exp_q[0]) begin failures++; $display("FAIL single_pkt: got %h required %h", pkt_q[0], exp_q[0]); end
      checks++;
      if (pkt_q[0][95:80] !== 16'h1800 || pkt_q[0][63:48] !== 16'h0007) begin
        failures++; $display("FAIL single_fields: flit5=%h ts=%h required 1800 0007", pkt_q[0][95:80], pkt_q[0][63:48]);
      end
    end
  endtask

  task automatic test_filter();
    pkt_t got1, e1;
    int n, k, lastbad;
    do_reset();
    n = 0; k = 0; lastbad = 0; got1 = '0;
    e1 = mk_pkt(0, tsm, 32'hCAFE_0010, 32'hBEEF_0020, 1'b0, 1'b0, 10'd0);
    drive(2'b01, 2'b00, 2'b00, 32'hCAFE_0010, 32'hBEEF_0020, 32'h0, 32'h0);
    clear_inputs();
    while (n < 10 && k < 40) begin
      if (debug_out1[17]) begin
        got1[n*16 +: 16] = debug_out1[15:0];
        if (debug_out1[16] != (n == 9)) lastbad++;
        n++;
      end
      tick();
      k++;
    end
    checks++;
    if (n != 10 || lastbad != 0) begin failures++; $display("FAIL nofilter_flits: got %0d flits (%0d bad last), required 10", n, lastbad); end
    checks++;
    if (got1 !== e1) begin failures++; $display("FAIL nofilter_pkt: got %h required %h", got1, e1); end
    checks++;
    if (got1[91:90] !== 2'b00) begin failures++; $display("FAIL nofilter_jaljr: got %b required 00", got1[91:90]); end
    idle(10);
    checks++;
    if (pkt_q.size() != 0 || overflow1 !== 2'b00) begin
      failures++; $display("FAIL filter_drop: got %0d packets ovf_nf=%b, required 0 and 00", pkt_q.size(), overflow1);
    end
  endtask

  task automatic test_overflow();
    pkt_t t;
    do_reset();
    ready = 1'b0;
    drive(2'b10, 2'b00, 2'b10, 32'h0, 32'h0, 32'h1111_0001, 32'h1111_0002);
    idle(1);
    for (int i = 0; i < 6; i++)
      drive(2'b01, 2'b01, 2'b00, 32'h2000_0000 + i, 32'h3000_0000 + i, 32'h0, 32'h0);
    idle(1);
    while (exp_q.size() > 1 + DEPTH) void'(exp_q.pop_back());
    t = exp_q[1];
    t[89:80] = 10'(6 - DEPTH);
    exp_q[1] = t;
    checks++;
    if (overflow0 !== 2'b01) begin failures++; $display("FAIL ovf_flag: got %b required 01", overflow0); end
    ready = 1'b1;
    wait_pkts(1 + DEPTH, 200, "overflow");
    idle(30);
    checks++;
    if (pkt_q.size() != 1 + DEPTH) begin failures++; $display("FAIL ovf_count: got %0d required %0d", pkt_q.size(), 1 + DEPTH); end
    for (int i = 0; i < 1 + DEPTH && i < pkt_q.size(); i++) begin
      checks++;
      if (pkt_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_pkt%0d: got %h required %h", i, pkt_q[i], exp_q[i]); end
    end
    checks++;
    if (overflow0 !== 2'b01) begin failures++; $display("FAIL ovf_sticky: got %b required 01", overflow0); end
  endtask

  task automatic test_round_robin();
    do_reset();
    drive(2'b11, 2'b01, 2'b10, 32'hA000_0000, 32'hA000_0004, 32'hB000_0000, 32'hB000_0004);
    wait_pkts(2, 80, "rr1");
    drive(2'b11, 2'b11, 2'b00, 32'hA100_0000, 32'hA100_0004, 32'hB100_0000, 32'hB100_0004);
    wait_pkts(4, 80, "rr2");
    for (int i = 0; i < 4 && i < pkt_q.size(); i++) begin
      checks++;
      if (pkt_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rr_pkt%0d: got ch %0d %h required ch %0d %h", i, pkt_q[i][95:92], pkt_q[i], exp_q[i][95:92], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++)
      drive(2'b01, 2'b00, 2'b01, 32'h4000_0000 + 4*i, 32'h5000_0000 + 4*i, 32'h0, 32'h0);
    wait_pkts(3, 100, "b2b");
    for (int i = 0; i < 3 && i < pkt_q.size(); i++) begin
      checks++;
      if (pkt_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_pkt%0d: got %h required %h", i, pkt_q[i], exp_q[i]); end
      if (i > 0) begin
        checks++;
        if (pkt_tq[i] - pkt_tq[i-1] < 10) begin failures++; $display("FAIL b2b_gap%0d: got %0d cycles required >=10", i, pkt_tq[i] - pkt_tq[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int cnt [CH];
    int target, k, found;
    logic [1:0] v, j, r;
    do_reset();
    target = 0;
    for (int round = 0; round < 6; round++) begin
      for (int c = 0; c < CH; c++) cnt[c] = 0;
      for (int s = 0; s < 12; s++) begin
        ready  = 1'($urandom);
        enable = ($urandom_range(0, 9) != 0);
        v = 2'($urandom); j = 2'($urandom); r = 2'($urandom);
        for (int c = 0; c < CH; c++) begin
          if (cnt[c] >= DEPTH - 1) v[c] = 1'b0;
          else if (enable && v[c] && (j[c] || r[c])) cnt[c]++;
        end
        drive(v, j, r, $urandom, $urandom, $urandom, $urandom);
      end
      target += cnt[0] + cnt[1];
      enable = 1'b1;
      clear_inputs();
      k = 0;
      while (pkt_q.size() < target && k < 1500) begin
        ready = 1'($urandom);
        tick();
        k++;
      end
      checks++;
      if (pkt_q.size() < target) begin failures++; $display("FAIL bp_drain%0d: got %0d packets required %0d", round, pkt_q.size(), target); end
    end
    ready = 1'b1;
    idle(30);
    checks++;
    if (pkt_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count: got %0d required %0d", pkt_q.size(), exp_q.size()); end
    for (int i = 0; i < pkt_q.size(); i++) begin
      found = -1;
      for (int e = 0; e < exp_q.size(); e++)
        if (found < 0 && exp_q[e][95:92] == pkt_q[i][95:92]) found = e;
      checks++;
      if (found < 0) begin
        failures++; $display("FAIL bp_unexpected: got %h required no packet", pkt_q[i]);
      end else begin
        if (pkt_q[i] !== exp_q[found]) begin failures++; $display("FAIL bp_pkt%0d: got %h required %h", i, pkt_q[i], exp_q[found]); end
        exp_q.delete(found);
      end
    end
    checks++;
    if (stab_viol != 0 || fmt_err != 0) begin
      failures++; $display("FAIL bp_handshake: got %0d hold and %0d last violations, required 0", stab_viol, fmt_err);
    end
  endtask

  task automatic test_reset_mid();
    int n, k;
    do_reset();
    drive(2'b01, 2'b01, 2'b00, 32'h7777_0000, 32'h8888_0000, 32'h0, 32'h0);
    clear_inputs();
    n = 0; k = 0;
    while (n < 4 && k < 20) begin
      if (debug_out0[17]) n++;
      tick();
      k++;
    end
    checks++;
    if (n != 4 || debug_out0[17] !== 1'b1) begin failures++; $display("FAIL mid_reach: got %0d flits valid=%b required 4 and 1", n, debug_out0[17]); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (debug_out0 !== 18'h0 || overflow0 !== 2'b00) begin
      failures++; $display("FAIL mid_async: got out=%h ovf=%b required 0", debug_out0, overflow0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    pkt_q.delete(); pkt_tq.delete(); exp_q.delete();
    drive(2'b10, 2'b00, 2'b10, 32'h0, 32'h0, 32'h9999_0001, 32'h9999_0002);
    wait_pkts(1, 60, "mid_new");
    idle(30);
    checks++;
    if (pkt_q.size() != 1) begin failures++; $display("FAIL mid_count: got %0d packets required 1", pkt_q.size()); end
    if (pkt_q.size() >= 1) begin
      checks++;
      if (pkt_q[0] !== exp_q[0]) begin failures++; $display("FAIL mid_pkt: got %h required %h", pkt_q[0], exp_q[0]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_jal();
    test_filter();
    test_overflow();
    test_round_robin();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
